// File: rtl/full_adder_pkg.sv
// Shared types and limits for the registered ripple-carry full adder.
// The FULL_ADDER_OVF_EN build option lives in full_adder_pipe; nothing here depends on it.
package full_adder_pkg;

  localparam int WIDTH_MAX = 64;

  // Result word sized for the widest legal adder; narrower builds zero the upper sum bits.
  typedef struct packed {
    logic                 carry;
    logic [WIDTH_MAX-1:0] sum;
  } fa_result_t;

endpackage

// File: rtl/full_adder_cell.sv
// Combinational 1-bit full adder cell: one link of the ripple chain.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder_pipe.sv
// Registered WIDTH-bit ripple-carry adder: {carry, sum} = a + b + cin, one clock of latency.
// Build option FULL_ADDER_OVF_EN adds a registered signed-overflow output.
module full_adder_pipe
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             overflow
`endif
);

  logic [WIDTH:0]   c_chain;
  logic [WIDTH-1:0] s_chain;
  fa_result_t       res_c;
  logic             unused_pad;

  logic             vld_p1;
  logic [WIDTH-1:0] sum_p1;
  logic             carry_p1;

  assign c_chain[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a     (a[i]),
      .b     (b[i]),
      .cin   (c_chain[i]),
      .sum   (s_chain[i]),
      .carry (c_chain[i+1])
    );
  end

  always_comb begin
    res_c              = '0;
    res_c.sum[WIDTH-1:0] = s_chain;
    res_c.carry        = c_chain[WIDTH];
  end

  // Upper pad bits of the shared result type are always zero for narrow builds.
  assign unused_pad = ^(res_c.sum >> WIDTH);

  // ---- stage p1: output and valid registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      sum_p1   <= '0;
      carry_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        sum_p1   <= res_c.sum[WIDTH-1:0];
        carry_p1 <= res_c.carry;
      end
    end
  end

  assign out_valid = vld_p1;
  assign sum       = sum_p1;
  assign carry     = carry_p1;

`ifdef FULL_ADDER_OVF_EN
  logic ovf_p1;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_p1 <= 1'b0;
    end else if (in_valid) begin
      ovf_p1 <= c_chain[WIDTH-1] ^ c_chain[WIDTH];
    end
  end

  assign overflow = ovf_p1;
`endif

endmodule

// File: tb/tb_full_adder_pipe.sv
// Directed bench for full_adder_pipe at WIDTH=1 and WIDTH=8, with optional overflow checks.
module tb_full_adder_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       iv1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
  logic       ov1, s1, c1;
  logic       iv8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ov8, c8;
  logic [7:0] s8;
`ifdef FULL_ADDER_OVF_EN
  logic       ovf1, ovf8;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  full_adder_pipe #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1), .cin(cin1),
    .out_valid(ov1), .sum(s1), .carry(c1)
`ifdef FULL_ADDER_OVF_EN
    , .overflow(ovf1)
`endif
  );

  full_adder_pipe #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov8), .sum(s8), .carry(c8)
`ifdef FULL_ADDER_OVF_EN
    , .overflow(ovf8)
`endif
  );

  typedef struct {
    logic       a, b, cin;
    logic [1:0] exp_cs;  // {carry, sum}
  } vec1_t;

  typedef struct {
    logic [7:0] a, b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_carry;
    logic       exp_ovf;
  } vec8_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec1_t tt1 [8];
  vec8_t tt8 [7];

  initial begin
    logic [8:0] exp9;
    logic       exp_ovf;

    tt1[0] = '{1'b0, 1'b0, 1'b0, 2'b00};
    tt1[1] = '{1'b0, 1'b0, 1'b1, 2'b01};
    tt1[2] = '{1'b0, 1'b1, 1'b0, 2'b01};
    tt1[3] = '{1'b0, 1'b1, 1'b1, 2'b10};
    tt1[4] = '{1'b1, 1'b0, 1'b0, 2'b01};
    tt1[5] = '{1'b1, 1'b0, 1'b1, 2'b10};
    tt1[6] = '{1'b1, 1'b1, 1'b0, 2'b10};
    tt1[7] = '{1'b1, 1'b1, 1'b1, 2'b11};

    tt8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tt8[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tt8[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tt8[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tt8[4] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};
    tt8[5] = '{8'h10, 8'h10, 1'b0, 8'h20, 1'b0, 1'b0};
    tt8[6] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};

    // Asynchronous reset at start, checked before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_w1_vld", 64'(ov1), 64'd0);
    chk("rst_w1_cs",  64'({c1, s1}), 64'd0);
    chk("rst_w8_vld", 64'(ov8), 64'd0);
    chk("rst_w8_cs",  64'({c8, s8}), 64'd0);
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;

    // WIDTH=1 exhaustive truth table, back-to-back.
    for (int i = 0; i < 8; i++) begin
      iv1 = 1'b1; a1 = tt1[i].a; b1 = tt1[i].b; cin1 = tt1[i].cin;
      tick();
      chk($sformatf("tt1_%0d_cs", i), 64'({c1, s1}), 64'(tt1[i].exp_cs));
      chk($sformatf("tt1_%0d_vld", i), 64'(ov1), 64'd1);
    end

    // Mid-stream asynchronous reset while outputs are all ones.
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    tick();
    chk("pre_rst_cs", 64'({ov1, c1, s1}), 64'b111);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cs", 64'({ov1, c1, s1}), 64'b000);
    tick();
    chk("rst_held_cs", 64'({ov1, c1, s1}), 64'b000);
    @(negedge clk);
    rst = 1'b0;
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0; iv1 = 1'b1;
    tick();
    chk("post_rst_cs",  64'({c1, s1}), 64'b10);
    chk("post_rst_vld", 64'(ov1), 64'd1);

    // Hold: result persists once in_valid drops.
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b1; iv1 = 1'b1;
    tick();
    chk("hold_load_cs", 64'({ov1, c1, s1}), 64'b110);
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; iv1 = 1'b0;
    tick();
    chk("hold_1_cs",  64'({c1, s1}), 64'b10);
    chk("hold_1_vld", 64'(ov1), 64'd0);
    tick();
    chk("hold_2_cs",  64'({ov1, c1, s1}), 64'b010);

    // WIDTH=8 directed boundary vectors.
    for (int i = 0; i < 7; i++) begin
      iv8 = 1'b1; a8 = tt8[i].a; b8 = tt8[i].b; cin8 = tt8[i].cin;
      tick();
      chk($sformatf("tt8_%0d_sum", i),   64'(s8), 64'(tt8[i].exp_sum));
      chk($sformatf("tt8_%0d_carry", i), 64'(c8), 64'(tt8[i].exp_carry));
      chk($sformatf("tt8_%0d_vld", i),   64'(ov8), 64'd1);
`ifdef FULL_ADDER_OVF_EN
      chk($sformatf("tt8_%0d_ovf", i),   64'(ovf8), 64'(tt8[i].exp_ovf));
`endif
    end

    // WIDTH=8 random streaming, one result per cycle.
    for (int i = 0; i < 100; i++) begin
      iv8  = 1'b1;
      a8   = 8'($urandom_range(255));
      b8   = 8'($urandom_range(255));
      cin8 = 1'($urandom_range(1));
      exp9 = {1'b0, a8} + {1'b0, b8} + {8'd0, cin8};
      exp_ovf = (a8[7] == b8[7]) && (exp9[7] != a8[7]);
      tick();
      chk($sformatf("strm_%0d_res", i), 64'({c8, s8}), 64'(exp9));
      chk($sformatf("strm_%0d_vld", i), 64'(ov8), 64'd1);
`ifdef FULL_ADDER_OVF_EN
      chk($sformatf("strm_%0d_ovf", i), 64'(ovf8), 64'(exp_ovf));
`endif
    end
    iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    tick();
    chk("strm_end_vld", 64'(ov8), 64'd0);
    chk("strm_end_hold", 64'({c8, s8}), 64'(exp9));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
